// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry controller.
// Button codes are col*4+row as delivered by the numpad scanner.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_WAIT = 3'd2,
    ST_RES  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    KC_NONE  = 3'd0,
    KC_DIGIT = 3'd1,
    KC_OP    = 3'd2,
    KC_EQ    = 3'd3,
    KC_CLR   = 3'd4,
    KC_BKSP  = 3'd5
  } key_class_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [3:0] BTN_A = 4'd12;
  localparam logic [3:0] BTN_B = 4'd13;
  localparam logic [3:0] BTN_C = 4'd14;
  localparam logic [3:0] BTN_D = 4'd15;
  localparam logic [3:0] BTN_E = 4'd11;
  localparam logic [3:0] BTN_F = 4'd7;

  // Main-keyboard digit lookup: {valid, digit}
  function automatic logic [4:0] digit_of_code(input logic [3:0] code);
    case (code)
      4'd3:    digit_of_code = {1'b1, 4'd0};
      4'd0:    digit_of_code = {1'b1, 4'd1};
      4'd4:    digit_of_code = {1'b1, 4'd2};
      4'd8:    digit_of_code = {1'b1, 4'd3};
      4'd1:    digit_of_code = {1'b1, 4'd4};
      4'd5:    digit_of_code = {1'b1, 4'd5};
      4'd9:    digit_of_code = {1'b1, 4'd6};
      4'd2:    digit_of_code = {1'b1, 4'd7};
      4'd6:    digit_of_code = {1'b1, 4'd8};
      4'd10:   digit_of_code = {1'b1, 4'd9};
      default: digit_of_code = {1'b0, 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Classifies a numpad change event into digit / operator / equals / clear /
// backspace. Operator codes 12..15 map to add..div through their low two bits.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic [5:0]  key_event,
  output key_class_t  key_class,
  output logic [3:0]  digit,
  output logic [1:0]  op
);

  logic [4:0] dig_s;

  assign dig_s = digit_of_code(key_event[3:0]);

  // Event classification
  always_comb begin
    key_class = KC_NONE;
    digit     = 4'd0;
    op        = OP_ADD;
    if (key_event[5] && key_event[4]) begin
      if (dig_s[4]) begin
        key_class = KC_DIGIT;
        digit     = dig_s[3:0];
      end else begin
        case (key_event[3:0])
          BTN_A, BTN_B, BTN_C, BTN_D: begin
            key_class = KC_OP;
            op        = key_event[1:0];
          end
          BTN_E:   key_class = KC_EQ;
          BTN_F:   key_class = KC_CLR;
          default: key_class = KC_NONE;
        endcase
      end
    end else if (key_event[5] && (key_event[3:0] == BTN_A)) begin
      key_class = KC_BKSP;
    end else begin
      key_class = KC_NONE;
    end
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: builds operands from key events, issues the
// operation to the ALU over req/ack and keeps a registered display value.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       key_event,
  output logic             alu_req,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_ack,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] TEN      = WIDTH'(10);

  key_class_t       kc_s;
  logic [3:0]       kdig_s;
  logic [1:0]       kop_s;

  state_t           state_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CNT_W-1:0] cnt_a_r, cnt_b_r;
  logic [1:0]       op_r, pend_op_r;
  logic             pend_op_vld_r, pend_clr_r;

  logic [WIDTH-1:0] a_push_s, b_push_s, a_bksp_s, b_bksp_s;
  logic [CNT_W-1:0] cnt_a_dec_s, cnt_b_dec_s;
  logic             full_clr_s, issue_s;

  calc_key_decode u_decode (
    .key_event (key_event),
    .key_class (kc_s),
    .digit     (kdig_s),
    .op        (kop_s)
  );

  assign a_push_s    = a_r * TEN + WIDTH'(kdig_s);
  assign b_push_s    = b_r * TEN + WIDTH'(kdig_s);
  assign a_bksp_s    = a_r / TEN;
  assign b_bksp_s    = b_r / TEN;
  assign cnt_a_dec_s = (cnt_a_r != CNT_ZERO) ? cnt_a_r - CNT_ONE : CNT_ZERO;
  assign cnt_b_dec_s = (cnt_b_r != CNT_ZERO) ? cnt_b_r - CNT_ONE : CNT_ZERO;

  // A clear seen while waiting only takes effect once the ALU acknowledges
  assign full_clr_s = ((kc_s == KC_CLR) && (state_r != ST_WAIT)) ||
                      ((state_r == ST_WAIT) && alu_ack && (pend_clr_r || (kc_s == KC_CLR)));
  assign issue_s    = (state_r == ST_B) && (cnt_b_r != CNT_ZERO) &&
                      ((kc_s == KC_EQ) || (kc_s == KC_OP));

  // FSM, operand registers, ALU handshake and display registers
  always_ff @(posedge clock) begin
    if (!reset_n || full_clr_s) begin
      state_r       <= ST_A;
      a_r           <= VAL_ZERO;
      b_r           <= VAL_ZERO;
      cnt_a_r       <= CNT_ZERO;
      cnt_b_r       <= CNT_ZERO;
      op_r          <= OP_ADD;
      pend_op_r     <= OP_ADD;
      pend_op_vld_r <= 1'b0;
      pend_clr_r    <= 1'b0;
      alu_req       <= 1'b0;
      alu_op        <= OP_ADD;
      alu_a         <= VAL_ZERO;
      alu_b         <= VAL_ZERO;
      disp_value    <= VAL_ZERO;
      disp_err      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_r)
        ST_A: begin
          case (kc_s)
            KC_DIGIT: begin
              if (cnt_a_r < MAX_CNT) begin
                a_r        <= a_push_s;
                cnt_a_r    <= cnt_a_r + CNT_ONE;
                disp_value <= a_push_s;
              end
            end
            KC_OP: begin
              op_r    <= kop_s;
              b_r     <= VAL_ZERO;
              cnt_b_r <= CNT_ZERO;
              state_r <= ST_B;
            end
            KC_BKSP: begin
              a_r        <= a_bksp_s;
              cnt_a_r    <= cnt_a_dec_s;
              disp_value <= a_bksp_s;
            end
            default: ;
          endcase
        end
        ST_B: begin
          if (issue_s) begin
            alu_req       <= 1'b1;
            alu_op        <= op_r;
            alu_a         <= a_r;
            alu_b         <= b_r;
            busy          <= 1'b1;
            pend_op_r     <= kop_s;
            pend_op_vld_r <= (kc_s == KC_OP);
            disp_value    <= a_r;
            state_r       <= ST_WAIT;
          end else begin
            case (kc_s)
              KC_DIGIT: begin
                if (cnt_b_r < MAX_CNT) begin
                  b_r        <= b_push_s;
                  cnt_b_r    <= cnt_b_r + CNT_ONE;
                  disp_value <= b_push_s;
                end
              end
              KC_BKSP: begin
                b_r        <= b_bksp_s;
                cnt_b_r    <= cnt_b_dec_s;
                disp_value <= (cnt_b_dec_s != CNT_ZERO) ? b_bksp_s : a_r;
              end
              KC_OP:   op_r <= kop_s;
              default: ;
            endcase
          end
        end
        ST_WAIT: begin
          if (kc_s == KC_CLR) begin
            pend_clr_r <= 1'b1;
          end
          if (alu_ack) begin
            alu_req       <= 1'b0;
            busy          <= 1'b0;
            pend_op_vld_r <= 1'b0;
            if (alu_err) begin
              disp_err   <= 1'b1;
              disp_value <= VAL_ZERO;
              state_r    <= ST_ERR;
            end else begin
              a_r        <= alu_result;
              cnt_a_r    <= MAX_CNT;
              disp_value <= alu_result;
              if (pend_op_vld_r) begin
                op_r    <= pend_op_r;
                b_r     <= VAL_ZERO;
                cnt_b_r <= CNT_ZERO;
                state_r <= ST_B;
              end else begin
                state_r <= ST_RES;
              end
            end
          end
        end
        ST_RES: begin
          case (kc_s)
            KC_DIGIT: begin
              a_r        <= WIDTH'(kdig_s);
              cnt_a_r    <= CNT_ONE;
              disp_value <= WIDTH'(kdig_s);
              state_r    <= ST_A;
            end
            KC_OP: begin
              op_r    <= kop_s;
              b_r     <= VAL_ZERO;
              cnt_b_r <= CNT_ZERO;
              state_r <= ST_B;
            end
            default: ;
          endcase
        end
        ST_ERR: begin
          disp_err   <= 1'b1;
          disp_value <= VAL_ZERO;
        end
        default: state_r <= ST_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed scenarios followed by random key/ack traffic, all checked against a
// value-level calculator model (operands as integers, states as names).
module tb_calc_entry_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [5:0]  key_event;
  logic        alu_req;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_ack;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] disp_value;
  logic        disp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int digit_code[10] = '{3, 0, 4, 8, 1, 5, 9, 2, 6, 10};

  // reference model
  string ph;
  int ma, mb, na, nb, mop, pend_op;
  bit pend_clr;
  int ra, rb, rop;

  always #10 clock = ~clock;

  calc_entry_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_event  (key_event),
    .alu_req    (alu_req),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ack    (alu_ack),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_err   (disp_err),
    .busy       (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int code_digit(input int code);
    for (int i = 0; i < 10; i++) if (digit_code[i] == code) return i;
    return -1;
  endfunction

  task automatic model_reset();
    ph = "A"; ma = 0; mb = 0; na = 0; nb = 0; mop = 0; pend_op = -1; pend_clr = 1'b0;
  endtask

  task automatic model_key(input bit chg, input bit main_kb, input int code);
    int d;
    bit is_op, is_eq, is_clr, is_bk;
    if (!chg) return;
    d      = main_kb ? code_digit(code) : -1;
    is_op  = main_kb && (code >= 12);
    is_eq  = main_kb && (code == 11);
    is_clr = main_kb && (code == 7);
    is_bk  = !main_kb && (code == 12);
    if (ph == "WAIT") begin
      if (is_clr) pend_clr = 1'b1;
      return;
    end
    if (is_clr) begin
      model_reset();
      return;
    end
    if (ph == "A") begin
      if (d >= 0) begin
        if (na < 4) begin ma = ma * 10 + d; na++; end
      end else if (is_op) begin
        mop = code - 12; mb = 0; nb = 0; ph = "B";
      end else if (is_bk) begin
        ma = ma / 10; if (na > 0) na--;
      end
    end else if (ph == "B") begin
      if (d >= 0) begin
        if (nb < 4) begin mb = mb * 10 + d; nb++; end
      end else if (is_bk) begin
        mb = mb / 10; if (nb > 0) nb--;
      end else if ((is_eq || is_op) && nb > 0) begin
        ra = ma; rb = mb; rop = mop;
        pend_op = is_op ? code - 12 : -1;
        ph = "WAIT";
      end else if (is_op) begin
        mop = code - 12;
      end
    end else if (ph == "RES") begin
      if (d >= 0) begin
        ma = d; na = 1; ph = "A";
      end else if (is_op) begin
        mop = code - 12; mb = 0; nb = 0; ph = "B";
      end
    end
  endtask

  task automatic model_ack(input int res, input bit err);
    if (pend_clr) begin
      model_reset();
    end else if (err) begin
      ph = "ERR"; pend_op = -1;
    end else begin
      ma = res; na = 4;
      if (pend_op >= 0) begin
        mop = pend_op; pend_op = -1; mb = 0; nb = 0; ph = "B";
      end else begin
        ph = "RES";
      end
    end
  endtask

  function automatic int exp_disp();
    if (ph == "ERR") return 0;
    if (ph == "B" && nb > 0) return mb;
    return ma;
  endfunction

  task automatic alu_calc(output int res, output bit err);
    longint r;
    err = 1'b0;
    case (rop)
      0: r = longint'(ra) + rb;
      1: r = longint'(ra) - rb;
      2: r = longint'(ra) * rb;
      default: r = (rb == 0) ? 0 : ra / rb;
    endcase
    if (r < 0 || r > 65535 || (rop == 3 && rb == 0)) err = 1'b1;
    res = int'(r & 64'hFFFF);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "/disp"}, int'(disp_value), exp_disp());
    chk({tag, "/err"}, int'(disp_err), (ph == "ERR") ? 1 : 0);
    chk({tag, "/busy"}, int'(busy), (ph == "WAIT") ? 1 : 0);
    chk({tag, "/req"}, int'(alu_req), (ph == "WAIT") ? 1 : 0);
    if (ph == "WAIT") begin
      chk({tag, "/a"}, int'(alu_a), ra);
      chk({tag, "/b"}, int'(alu_b), rb);
      chk({tag, "/op"}, int'(alu_op), rop);
    end
  endtask

  task automatic step(input string tag, input bit chg, input bit main_kb, input int code,
                      input bit ack, input int res, input bit err);
    bit in_wait;
    @(negedge clock);
    key_event  = {chg, main_kb, code[3:0]};
    alu_ack    = ack;
    alu_result = res[15:0];
    alu_err    = err;
    in_wait    = (ph == "WAIT");
    @(posedge clock);
    #1;
    key_event = 6'd0; alu_ack = 1'b0; alu_result = 16'd0; alu_err = 1'b0;
    model_key(chg, main_kb, code);
    if (in_wait && ack) model_ack(res, err);
    check_outputs(tag);
  endtask

  task automatic press(input string tag, input bit main_kb, input int code);
    step(tag, 1'b1, main_kb, code, 1'b0, 0, 1'b0);
  endtask

  task automatic dig(input string tag, input int d);
    press(tag, 1'b1, digit_code[d]);
  endtask

  task automatic do_ack(input string tag);
    int res;
    bit err;
    alu_calc(res, err);
    step(tag, 1'b0, 1'b1, 0, 1'b1, res, err);
  endtask

  initial begin
    reset_n = 1'b0; key_event = 6'd0; alu_ack = 1'b0; alu_result = 16'd0; alu_err = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_outputs("reset");

    // 12 + 3 = 15
    dig("s1", 1); dig("s1", 2); press("s1", 1'b1, 12); dig("s1", 3); press("s1", 1'b1, 11);
    chk("s1_req", int'(alu_req), 1);
    chk("s1_a", int'(alu_a), 12);
    chk("s1_b", int'(alu_b), 3);
    chk("s1_op", int'(alu_op), 0);
    do_ack("s1_ack");
    chk("s1_disp", int'(disp_value), 15);

    // digit limit and backspace
    for (int d = 1; d <= 5; d++) dig("s2", d);
    chk("s2_limit", int'(disp_value), 1234);
    press("s2_bksp", 1'b0, 12);
    chk("s2_bk", int'(disp_value), 123);

    // chained operator
    press("s3", 1'b1, 7);
    dig("s3", 9); press("s3", 1'b1, 14); dig("s3", 8); press("s3", 1'b1, 13);
    chk("s3_op", int'(alu_op), 2);
    do_ack("s3_ack");
    chk("s3_disp", int'(disp_value), 72);
    dig("s3", 2); press("s3", 1'b1, 11);
    chk("s3_a2", int'(alu_a), 72);
    chk("s3_b2", int'(alu_b), 2);

    // long wait with ignored digit events
    for (int i = 0; i < 20; i++) dig("s4_hold", $urandom_range(0, 9));
    do_ack("s4_ack");
    chk("s4_disp", int'(disp_value), 70);

    // clear during wait drops the result
    press("s5", 1'b1, 7); dig("s5", 4); press("s5", 1'b1, 12); dig("s5", 1); press("s5", 1'b1, 11);
    press("s5_clr", 1'b1, 7);
    step("s5_ack", 1'b0, 1'b1, 0, 1'b1, 5, 1'b0);
    chk("s5_disp", int'(disp_value), 0);

    // divide by zero error
    dig("s6", 7); press("s6", 1'b1, 15); dig("s6", 0); press("s6", 1'b1, 11);
    do_ack("s6_ack");
    chk("s6_err", int'(disp_err), 1);
    dig("s6_ign", 3); dig("s6_ign", 4);
    press("s6_clr", 1'b1, 7);
    chk("s6_clr_err", int'(disp_err), 0);
    chk("s6_clr_disp", int'(disp_value), 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit chg, main_kb;
      int code;
      chg     = ($urandom_range(0, 9) != 0);
      main_kb = ($urandom_range(0, 4) != 0);
      code    = $urandom_range(0, 15);
      if (ph == "WAIT" && $urandom_range(0, 3) == 0) begin
        int res;
        bit err;
        alu_calc(res, err);
        step("rnd_ack", chg && ($urandom_range(0, 1) == 1), main_kb, code, 1'b1, res, err);
      end else begin
        step("rnd", chg, main_kb, code, 1'b0, 0, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
